// File: rtl/bus_slave_mem.sv
// Word-addressed memory slave with programmable wait states and
// saturating read/write completion counters.
// Ports: clk, reset (sync, high), req/addr/cmd/wdata in,
//   ack/rdata out, rd_count/wr_count completed-traffic counters.
module bus_slave_mem #(
  parameter int unsigned AW          = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        cmd,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    GAP
  } state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic          cmd_q;
  logic          oor_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [2**AW];

  logic          in_idle;
  logic          live_oor;
  logic          fire;
  logic [AW-1:0] a_idx;
  logic          a_cmd;
  logic          a_oor;
  logic [31:0]   a_wdata;
  logic          unused;

  // addr[31] selects the slave upstream; byte offset is meaningless here
  assign unused   = ^{addr[31], addr[1:0]};
  assign in_idle  = (state == IDLE);
  assign live_oor = (addr[30:AW+2] != '0);

  // With zero wait states the ack is decided on the accept edge,
  // so the live request fields must be used instead of the copies.
  assign a_idx   = in_idle ? addr[AW+1:2] : idx_q;
  assign a_cmd   = in_idle ? cmd          : cmd_q;
  assign a_oor   = in_idle ? live_oor     : oor_q;
  assign a_wdata = in_idle ? wdata        : wdata_q;

  always_comb begin
    fire = 1'b0;
    unique case (state)
      IDLE:    fire = req && (WC == 4'd0);
      WAIT:    fire = (cnt == 4'd1);
      default: fire = 1'b0;
    endcase
  end

  // Memory is deliberately left out of reset; a reset on the
  // completing edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && fire && a_cmd && !a_oor)
      mem[a_idx] <= a_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ack      <= 1'b0;
      rdata    <= '0;
      rd_count <= '0;
      wr_count <= '0;
      cnt      <= '0;
      idx_q    <= '0;
      cmd_q    <= 1'b0;
      oor_q    <= 1'b0;
      wdata_q  <= '0;
    end else begin
      ack   <= fire;
      rdata <= '0;
      if (fire) begin
        if (a_cmd) begin
          if (wr_count != 16'hFFFF)
            wr_count <= wr_count + 16'd1;
        end else begin
          rdata <= a_oor ? ERR_DATA : mem[a_idx];
          if (rd_count != 16'hFFFF)
            rd_count <= rd_count + 16'd1;
        end
      end

      unique case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= addr[AW+1:2];
            cmd_q   <= cmd;
            oor_q   <= live_oor;
            wdata_q <= wdata;
            cnt     <= WC;
            state   <= (WC == 4'd0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= ACK;
        end
        ACK: begin
          state <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave_mem.sv
// Self-checking bench: two slaves (2 and 0 wait states) driven by
// directed and random transactions against a word-level model.
module tb_bus_slave_mem;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic        req_v   [2];
  logic [31:0] addr_v  [2];
  logic        cmd_v   [2];
  logic [31:0] wdata_v [2];
  logic        ack_v   [2];
  logic [31:0] rdata_v [2];
  logic [15:0] rd_v    [2];
  logic [15:0] wr_v    [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [2][256];
  bit          vld [2][256];
  int          rdc [2];
  int          wrc [2];

  always #5 clk = ~clk;

  bus_slave_mem #(.AW(8), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(rst_v[0]), .req(req_v[0]),
    .addr(addr_v[0]), .cmd(cmd_v[0]), .wdata(wdata_v[0]),
    .ack(ack_v[0]), .rdata(rdata_v[0]),
    .rd_count(rd_v[0]), .wr_count(wr_v[0])
  );

  bus_slave_mem #(.AW(8), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(rst_v[1]), .req(req_v[1]),
    .addr(addr_v[1]), .cmd(cmd_v[1]), .wdata(wdata_v[1]),
    .ack(ack_v[1]), .rdata(rdata_v[1]),
    .rd_count(rd_v[1]), .wr_count(wr_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on slave s; mess scrambles the bus
  // and drops req right after the accept edge.
  task automatic txn(input int s, input bit c, input logic [31:0] a,
                     input logic [31:0] d, input bit mess);
    int          w;
    bit          oor;
    int          ix;
    logic [31:0] exp_rd;
    logic [31:0] scr;
    w   = (s == 0) ? 2 : 0;
    oor = (a[30:10] != 21'h0);
    ix  = int'(a[9:2]);
    exp_rd = oor ? 32'hDEAD_BEEF : mdl[s][ix];
    if (c) begin
      if (!oor) begin
        mdl[s][ix] = d;
        vld[s][ix] = 1'b1;
      end
      if (wrc[s] < 65535) wrc[s]++;
    end else begin
      if (rdc[s] < 65535) rdc[s]++;
    end
    req_v[s]   = 1'b1;
    cmd_v[s]   = c;
    addr_v[s]  = a;
    wdata_v[s] = d;
    for (int k = 1; k <= w + 1; k++) begin
      tick();
      if (mess && k == 1) begin
        scr        = $urandom;
        addr_v[s]  = scr;
        wdata_v[s] = ~scr;
        req_v[s]   = 1'b0;
      end
      if (k <= w) begin
        chk("ack_early", 32'(ack_v[s]), 32'd0);
      end else begin
        chk("ack", 32'(ack_v[s]), 32'd1);
        if (!c) chk("rdata", rdata_v[s], exp_rd);
        chk("rd_count", 32'(rd_v[s]), rdc[s]);
        chk("wr_count", 32'(wr_v[s]), wrc[s]);
      end
    end
    req_v[s] = 1'b0;
    tick();
    chk("ack_gap", 32'(ack_v[s]), 32'd0);
    chk("rdata_gap", rdata_v[s], 32'd0);
    tick();
    chk("ack_idle", 32'(ack_v[s]), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] d;
    int          s;
    int          ix;
    bit          c;

    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; req_v[i] = 1'b0; cmd_v[i] = 1'b0;
      addr_v[i] = '0; wdata_v[i] = '0; rdc[i] = 0; wrc[i] = 0;
      for (int j = 0; j < 256; j++) begin
        mdl[i][j] = '0; vld[i][j] = 1'b0;
      end
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b0;
      chk("rst_ack", 32'(ack_v[i]), 32'd0);
      chk("rst_rdata", rdata_v[i], 32'd0);
      chk("rst_rd", 32'(rd_v[i]), 32'd0);
      chk("rst_wr", 32'(wr_v[i]), 32'd0);
    end
    tick();

    // latency, single write then read back, 2 wait states
    txn(0, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 1'b0);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);

    // zero wait states, addr[31] ignored
    txn(1, 1'b1, 32'h8000_0004, 32'h1234_5678, 1'b0);
    txn(1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    txn(1, 1'b0, 32'h8000_0004, 32'h0, 1'b0);

    // out of range read and write, word 0 untouched
    txn(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0);
    txn(0, 1'b0, 32'h0001_0000, 32'h0, 1'b0);
    txn(0, 1'b1, 32'h0001_0000, 32'hFFFF_0000, 1'b0);
    txn(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);

    // bus disturbed during WAIT
    txn(0, 1'b1, 32'h0000_0024, 32'hC0DE_0009, 1'b1);
    txn(0, 1'b0, 32'h0000_0024, 32'h0, 1'b1);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      s  = n % 2;
      r  = $urandom;
      d  = $urandom;
      ix = $urandom_range(0, 15);
      a  = {r[31], 21'h0, 8'(ix), r[1:0]};
      if (r[6:4] == 3'd0) a[30:10] = r[30:10] | 21'h1;
      c  = r[8] || !(vld[s][ix] || a[30:10] != 21'h0);
      txn(s, c, a, d, r[9]);
    end

    // reset while a write sits in WAIT
    txn(0, 1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0);
    req_v[0]   = 1'b1;
    cmd_v[0]   = 1'b1;
    addr_v[0]  = 32'h0000_0020;
    wdata_v[0] = 32'h3333_4444;
    tick();
    rst_v[0] = 1'b1;
    req_v[0] = 1'b0;
    tick();
    rst_v[0] = 1'b0;
    rdc[0] = 0;
    wrc[0] = 0;
    chk("rst_mid_rd", 32'(rd_v[0]), 32'd0);
    chk("rst_mid_wr", 32'(wr_v[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("rst_mid_ack", 32'(ack_v[0]), 32'd0);
      tick();
    end
    txn(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0);

    // write counter saturation
    @(negedge clk);
    force dut0.wr_count = 16'hFFFE;
    @(negedge clk);
    release dut0.wr_count;
    wrc[0] = 65534;
    #1;
    chk("sat_preload", 32'(wr_v[0]), 32'h0000_FFFE);
    tick();
    for (int k = 0; k < 3; k++)
      txn(0, 1'b1, 32'h0000_0030 + 32'(4 * k), 32'h5A5A_0000 + 32'(k), 1'b0);
    chk("sat_hold", 32'(wr_v[0]), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
